// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, alu opcodes and the alu request/response bundles.
// Pure type definitions; no logic.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5
   } aluop_t;

   typedef struct packed {
      aluop_t aluop;
      word_t  port_a;
      word_t  port_b;
   } alu_req_t;

   typedef struct packed {
      word_t result;
      logic  negative;
      logic  overflow;
      logic  zero;
   } alu_resp_t;

endpackage

// File: rtl/alu.sv
// Combinational alu: result plus negative/overflow/zero flags, zero latency, no flow control.
// Overflow is signed overflow and is only meaningful for add and subtract.
module alu
   import cpu_types_pkg::*;
(
   input  aluop_t aluop,
   input  word_t  port_a,
   input  word_t  port_b,
   output word_t  result,
   output logic   negative,
   output logic   overflow,
   output logic   zero
);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (aluop)
         ALU_ADD: begin
            result   = port_a + port_b;
            overflow = (port_a[WORD_W-1] == port_b[WORD_W-1]) &&
                       (result[WORD_W-1] != port_a[WORD_W-1]);
         end
         ALU_SUB: begin
            result   = port_a - port_b;
            overflow = (port_a[WORD_W-1] != port_b[WORD_W-1]) &&
                       (result[WORD_W-1] != port_a[WORD_W-1]);
         end
         ALU_AND: result = port_a & port_b;
         ALU_OR:  result = port_a | port_b;
         ALU_XOR: result = port_a ^ port_b;
         ALU_SLT: result = {{(WORD_W-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
         default: result = '0;
      endcase
      negative = result[WORD_W-1];
      zero     = (result == '0);
   end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first requester at or after ptr wins (mod N), zero latency.
// Returns an all-zero grant when nothing requests.
module rr_grant #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      // Outer loop walks priority order, inner loop finds the lane at that position.
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
               gnt[i]  = 1'b1;
               gnt_idx = IW'(i);
               found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu across NREQ valid/ready clients; 1-cycle accept-to-response latency.
// A single response register stalls all grants until its tagged owner drains it (drain+refill same cycle).
module alu_share_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  aluop_t            req_aluop  [NREQ],
   input  word_t             req_port_a [NREQ],
   input  word_t             req_port_b [NREQ],
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output word_t             resp_result,
   output logic              resp_negative,
   output logic              resp_overflow,
   output logic              resp_zero
);

   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0] resp_valid_d, resp_valid_q;
   alu_resp_t       resp_d, resp_q;
   logic [PW-1:0]   rr_ptr_d, rr_ptr_q;

   logic            slot_free;
   logic [NREQ-1:0] req_cand;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   alu_req_t        sel_req;
   alu_resp_t       alu_out;
   word_t           alu_result;
   logic            alu_neg, alu_ovf, alu_zero;

   // Only the tagged owner's ready can free the slot; stray ready bits fall out of the AND.
   assign slot_free = ~|resp_valid_q | (|(resp_valid_q & resp_ready));
   assign req_cand  = (slot_free && !RST) ? req_valid : '0;

   rr_grant #(.N(NREQ)) u_rr_grant (
      .req     (req_cand),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;

   always_comb begin
      sel_req.aluop  = req_aluop[gnt_idx];
      sel_req.port_a = req_port_a[gnt_idx];
      sel_req.port_b = req_port_b[gnt_idx];
   end

   alu u_alu (
      .aluop    (sel_req.aluop),
      .port_a   (sel_req.port_a),
      .port_b   (sel_req.port_b),
      .result   (alu_result),
      .negative (alu_neg),
      .overflow (alu_ovf),
      .zero     (alu_zero)
   );

   assign alu_out = '{result: alu_result, negative: alu_neg, overflow: alu_ovf, zero: alu_zero};

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_d       = resp_q;
      rr_ptr_d     = rr_ptr_q;
      if (slot_free) begin
         resp_valid_d = '0;
      end
      if (|gnt) begin
         resp_valid_d = gnt;
         resp_d       = alu_out;
         rr_ptr_d     = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         resp_valid_q <= '0;
         resp_q       <= '0;
         rr_ptr_q     <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_q       <= resp_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign resp_valid    = resp_valid_q;
   assign resp_result   = resp_q.result;
   assign resp_negative = resp_q.negative;
   assign resp_overflow = resp_q.overflow;
   assign resp_zero     = resp_q.zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=2): stimulus pushes expected responses,
// a negedge monitor pops and compares them as responses are consumed.
module tb_alu_share_arbiter;
   import cpu_types_pkg::*;

   localparam int NREQ = 2;

   logic            CLK = 1'b0;
   logic            RST;
   logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
   aluop_t          req_aluop  [NREQ];
   word_t           req_port_a [NREQ];
   word_t           req_port_b [NREQ];
   word_t           resp_result;
   logic            resp_negative, resp_overflow, resp_zero;

   typedef struct packed {
      logic [1:0] tag;
      word_t      result;
      logic [2:0] noz;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   // Fairness table: entry k is the op of the lane expected to win in cycle k.
   aluop_t     fop  [6] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR};
   word_t      fa   [6] = '{32'h10, 32'h5, 32'h80000000, 32'hF0F0F0F0, 32'h0000000F, 32'hFFFFFFFF};
   word_t      fb   [6] = '{32'h20, 32'h5, 32'h00000001, 32'hFF00FF00, 32'h000000F0, 32'hFFFFFFFF};
   word_t      fres [6] = '{32'h30, 32'h0, 32'h7FFFFFFF, 32'hF000F000, 32'h000000FF, 32'h00000000};
   logic [2:0] fnoz [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001};

   alu_share_arbiter #(.NREQ(NREQ)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_aluop     (req_aluop),
      .req_port_a    (req_port_a),
      .req_port_b    (req_port_b),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_result   (resp_result),
      .resp_negative (resp_negative),
      .resp_overflow (resp_overflow),
      .resp_zero     (resp_zero)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int lane, input aluop_t op, input word_t a, input word_t b);
      req_aluop[lane]  = op;
      req_port_a[lane] = a;
      req_port_b[lane] = b;
   endtask

   task automatic push(input logic [1:0] tag, input word_t r, input logic [2:0] noz);
      exp_q.push_back('{tag: tag, result: r, noz: noz});
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: a response is checked in the cycle its owner consumes it.
   always @(negedge CLK) begin
      if (RST === 1'b0 && |(resp_valid & resp_ready)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual_tag=%b result=%0h expected=none", resp_valid, resp_result);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp", {27'd0, resp_valid, resp_result, resp_negative, resp_overflow, resp_zero},
                {27'd0, mon_e});
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      RST        = 1'b1;
      req_valid  = 2'b11;
      resp_ready = 2'b00;
      drive(0, ALU_ADD, 32'h1, 32'h1);
      drive(1, ALU_ADD, 32'h1, 32'h1);
      @(negedge CLK);
      chk("rst_req_ready",  64'(req_ready),  64'h0);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_result",     64'(resp_result), 64'h0);
      chk("rst_flags",      64'({resp_negative, resp_overflow, resp_zero}), 64'h0);

      // Fairness: both lanes valid, drained every cycle.
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         RST        = 1'b0;
         req_valid  = 2'b11;
         resp_ready = 2'b11;
         drive(k % 2, fop[k], fa[k], fb[k]);
         drive(1 - (k % 2), ALU_ADD, 32'h1, 32'h1);
         @(negedge CLK);
         chk("fair_gnt", 64'(req_ready), 64'(1 << (k % 2)));
         push(2'(1 << (k % 2)), fres[k], fnoz[k]);
      end
      next_cycle();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("fair_last_valid", 64'(resp_valid), 64'h2);
      next_cycle();
      resp_ready = 2'b00;
      @(negedge CLK);
      chk("drain_valid", 64'(resp_valid), 64'h0);
      chk("drain_hold_zero", 64'(resp_zero), 64'h1);

      // Single op with signed overflow.
      next_cycle();
      req_valid = 2'b01;
      drive(0, ALU_ADD, 32'h7FFFFFFF, 32'h00000001);
      @(negedge CLK);
      chk("single_gnt", 64'(req_ready), 64'h1);
      push(2'b01, 32'h80000000, 3'b110);
      next_cycle();
      req_valid  = 2'b00;
      resp_ready = 2'b01;
      @(negedge CLK);
      chk("single_valid", 64'(resp_valid), 64'h1);

      // Backpressure: response to req0 held while req1 waits.
      next_cycle();
      req_valid  = 2'b01;
      resp_ready = 2'b00;
      drive(0, ALU_ADD, 32'h3, 32'h4);
      @(negedge CLK);
      chk("bp_gnt0", 64'(req_ready), 64'h1);
      push(2'b01, 32'h7, 3'b000);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         req_valid = 2'b10;
         drive(1, ALU_SUB, 32'h100, 32'h1);
         @(negedge CLK);
         chk("bp_stall_gnt",   64'(req_ready),   64'h0);
         chk("bp_stall_valid", 64'(resp_valid),  64'h1);
         chk("bp_frozen",      64'(resp_result), 64'h7);
      end
      next_cycle();
      resp_ready = 2'b01;
      @(negedge CLK);
      chk("bp_gnt1", 64'(req_ready), 64'h2);
      push(2'b10, 32'hFF, 3'b000);
      next_cycle();
      req_valid  = 2'b00;
      resp_ready = 2'b10;
      @(negedge CLK);
      chk("bp_valid1", 64'(resp_valid), 64'h2);

      // Wrong-ready: ready on the other lane must not consume.
      next_cycle();
      req_valid  = 2'b01;
      resp_ready = 2'b00;
      drive(0, ALU_ADD, 32'h0, 32'h0);
      @(negedge CLK);
      chk("wr_gnt", 64'(req_ready), 64'h1);
      push(2'b01, 32'h0, 3'b001);
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         req_valid  = 2'b10;
         resp_ready = 2'b10;
         @(negedge CLK);
         chk("wr_valid_held", 64'(resp_valid), 64'h1);
         chk("wr_no_gnt",     64'(req_ready),  64'h0);
      end
      next_cycle();
      req_valid  = 2'b00;
      resp_ready = 2'b01;
      @(negedge CLK);

      // Mid-op reset drops a pending response for req1.
      next_cycle();
      req_valid  = 2'b10;
      resp_ready = 2'b00;
      drive(1, ALU_XOR, 32'hA5A5A5A5, 32'h5A5A5A5A);
      @(negedge CLK);
      chk("mr_gnt1", 64'(req_ready), 64'h2);
      push(2'b10, 32'hFFFFFFFF, 3'b100);
      next_cycle();
      @(negedge CLK);
      chk("mr_pending", 64'(resp_valid), 64'h2);
      chk("mr_no_gnt",  64'(req_ready),  64'h0);
      next_cycle();
      RST       = 1'b1;
      req_valid = 2'b11;
      @(negedge CLK);
      chk("mr_rst_gnt", 64'(req_ready), 64'h0);
      exp_q.delete();
      next_cycle();
      RST = 1'b0;
      drive(0, ALU_OR,  32'h1200, 32'h0034);
      drive(1, ALU_SUB, 32'h2,    32'h3);
      @(negedge CLK);
      chk("mr_dropped", 64'(resp_valid),  64'h0);
      chk("mr_cleared", 64'(resp_result), 64'h0);
      chk("mr_ptr0",    64'(req_ready),   64'h1);
      push(2'b01, 32'h1234, 3'b000);
      next_cycle();
      req_valid  = 2'b10;
      resp_ready = 2'b01;
      @(negedge CLK);
      chk("mr_regrant1", 64'(req_ready), 64'h2);
      push(2'b10, 32'hFFFFFFFF, 3'b100);
      next_cycle();
      req_valid  = 2'b00;
      resp_ready = 2'b10;
      @(negedge CLK);
      next_cycle();
      resp_ready = 2'b00;
      @(negedge CLK);
      chk("end_idle",  64'(resp_valid),   64'h0);
      chk("end_queue", 64'(exp_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
